feat_stream_drainer: RTL

Downstream consumer of the GAT accelerator's new-feature BRAM. After `gat_top` reports `gat_ready`, this block reads the entire feature memory through its port B. It streams the words out over an AXI-Stream master so the DMA can return them to the PS. Prefetch is bounded by credits and buffered in a small FIFO, so BRAM read latency never breaks the stream under backpressure.

---
 rtl/feat_drain_pkg.sv | 23 ++
 rtl/feat_sync_fifo.sv | 65 ++++++
 rtl/feat_stream_drainer.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/feat_drain_pkg.sv
// Shared types for the feature-BRAM stream drainer: FSM states, FIFO entry
// layout and the parameter legality check.
package feat_drain_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_FLUSH = 2'd2
  } drain_state_t;

  localparam int FEAT_DATA_W = 32;

  // The last tag travels with its word so tlast needs no separate counter.
  typedef struct packed {
    logic                   last;
    logic [FEAT_DATA_W-1:0] data;
  } feat_entry_t;

  function automatic bit feat_params_ok(input int rd_latency, input int fifo_depth);
    return ((rd_latency == 1) || (rd_latency == 2)) && (fifo_depth >= rd_latency + 1);
  endfunction

endpackage

// File: rtl/feat_sync_fifo.sv
// Synchronous FIFO with occupancy count; a push into a full FIFO is accepted
// when a pop happens in the same cycle.
module feat_sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             push_i,
  input  logic [W-1:0]     push_data_i,
  input  logic             pop_i,
  output logic [W-1:0]     head_o,
  output logic [CNT_W-1:0] count_o,
  output logic             empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full, do_push, do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full || do_pop);
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = next_ptr(wr_ptr_q);
    if (do_pop)  rd_ptr_d = next_ptr(rd_ptr_q);
    count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  always @(posedge clk) begin
    if (rst_n && !clr_i) assert (!(push_i && full && !do_pop));
  end

endmodule

// File: rtl/feat_stream_drainer.sv
// Reads the whole new-feature BRAM after gat_ready and streams it out over
// AXI-Stream, prefetching under a credit limit into a small FIFO.
module feat_stream_drainer
  import feat_drain_pkg::*;
#(
  parameter int NEW_FEATURE_WIDTH  = 32,
  parameter int NUM_SUBGRAPHS      = 2708,
  parameter int NUM_FEATURE_OUT    = 16,
  parameter int NEW_FEATURE_ADDR_W = $clog2(NUM_SUBGRAPHS * NUM_FEATURE_OUT),
  parameter int RD_LATENCY         = 2,
  parameter int FIFO_DEPTH         = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          gat_ready,
  input  logic                          drain_start,
  output logic [NEW_FEATURE_ADDR_W+1:0] feat_bram_addrb,
  input  logic [NEW_FEATURE_WIDTH-1:0]  feat_bram_dout,
  output logic [NEW_FEATURE_WIDTH-1:0]  m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,
  output logic                          drain_busy,
  output logic                          drain_done,
  output logic [NEW_FEATURE_ADDR_W:0]   beat_count
);

  localparam int NEW_FEATURE_DEPTH = NUM_SUBGRAPHS * NUM_FEATURE_OUT;
  localparam int ENTRY_W = $bits(feat_entry_t);
  localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam int SUM_W   = CNT_W + 1;
  localparam bit PARAMS_OK = feat_params_ok(RD_LATENCY, FIFO_DEPTH) &&
                             (NEW_FEATURE_WIDTH == FEAT_DATA_W);
  localparam logic [NEW_FEATURE_ADDR_W-1:0] LAST_ADDR = NEW_FEATURE_ADDR_W'(NEW_FEATURE_DEPTH - 1);
  localparam logic [NEW_FEATURE_ADDR_W:0]   LAST_BEAT = (NEW_FEATURE_ADDR_W + 1)'(NEW_FEATURE_DEPTH - 1);

  drain_state_t                  state_q, state_d;
  logic [NEW_FEATURE_ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [NEW_FEATURE_ADDR_W:0]   beat_q, beat_d;
  logic [CNT_W-1:0]              inflight_q, inflight_d;
  logic [RD_LATENCY-1:0]         vld_q, vld_d, tag_q, tag_d;
  logic                          busy_q, busy_d, done_q, done_d;
  logic                          start_ok, rd_en, last_issue, wr_en, pop, fifo_empty;
  logic [CNT_W-1:0]              fifo_count;
  logic [SUM_W-1:0]              occupancy, allowance;
  logic [ENTRY_W-1:0]            head_bits;
  feat_entry_t                   wr_entry, head_entry;

  assign start_ok = (state_q == ST_IDLE) && drain_start && gat_ready;
  assign pop      = !fifo_empty && m_axis_tready;
  assign wr_en    = vld_q[RD_LATENCY-1];

  // A pop this cycle frees a slot, so it counts toward the credit.
  assign occupancy  = SUM_W'(fifo_count) + SUM_W'(inflight_q);
  assign allowance  = SUM_W'(FIFO_DEPTH) + SUM_W'(pop);
  assign rd_en      = (state_q == ST_READ) && (occupancy < allowance);
  assign last_issue = rd_en && (rd_addr_q == LAST_ADDR);

  always_comb begin
    state_d    = state_q;
    rd_addr_d  = rd_addr_q;
    beat_d     = beat_q;
    busy_d     = busy_q;
    done_d     = done_q;
    inflight_d = inflight_q + CNT_W'(rd_en) - CNT_W'(wr_en);
    vld_d[0]   = rd_en;
    tag_d[0]   = last_issue;
    for (int i = 1; i < RD_LATENCY; i++) begin
      vld_d[i] = vld_q[i-1];
      tag_d[i] = tag_q[i-1];
    end
    if (pop) beat_d = beat_q + 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          state_d    = ST_READ;
          rd_addr_d  = '0;
          beat_d     = '0;
          done_d     = 1'b0;
          busy_d     = 1'b1;
          inflight_d = '0;
        end
      end
      ST_READ: begin
        if (last_issue) state_d = ST_FLUSH;
        else if (rd_en) rd_addr_d = rd_addr_q + 1'b1;
      end
      ST_FLUSH: begin
        if (pop && (beat_q == LAST_BEAT)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      rd_addr_q  <= '0;
      beat_q     <= '0;
      inflight_q <= '0;
      vld_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_addr_q  <= rd_addr_d;
      beat_q     <= beat_d;
      inflight_q <= inflight_d;
      vld_q      <= vld_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    tag_q <= tag_d;
  end

  assign wr_entry = '{last: tag_q[RD_LATENCY-1], data: feat_bram_dout};

  feat_sync_fifo #(
    .W     (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr_i       (start_ok),
    .push_i      (wr_en),
    .push_data_i (wr_entry),
    .pop_i       (pop),
    .head_o      (head_bits),
    .count_o     (fifo_count),
    .empty_o     (fifo_empty)
  );

  // Data is masked while empty so reset and idle present a zero word.
  assign head_entry      = feat_entry_t'(head_bits);
  assign m_axis_tvalid   = !fifo_empty;
  assign m_axis_tdata    = fifo_empty ? '0 : head_entry.data;
  assign m_axis_tlast    = !fifo_empty && head_entry.last;
  assign feat_bram_addrb = {rd_addr_q, 2'b00};
  assign drain_busy      = busy_q;
  assign drain_done      = done_q;
  assign beat_count      = beat_q;

  always @(posedge clk) begin
    assert (PARAMS_OK);
  end

endmodule
